phase_sequencer: RTL and testbench

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer.sv | 57 +++++
 tb/tb_phase_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// phase_sequencer: one-hot instruction phase sequencer with run, single-step, stall, skip and halt control.
module phase_sequencer #(
    parameter int NPHASE = 5,
    parameter int CW     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              step,
    input  logic              exec,
    input  logic              stall,
    input  logic              skip,
    input  logic              halt_req,
    output logic [NPHASE-1:0] p,
    output logic              busy,
    output logic              halted,
    output logic              inst_done,
    output logic [CW-1:0]     icount
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    localparam logic [NPHASE-1:0] FIRST = {1'b1, {(NPHASE-1){1'b0}}};
    state_t state, state_n;
    logic [NPHASE-1:0] p_n;
    logic exec_q, armed, exec_rise, leave;
    // armed stays low after reset until exec has been seen low, so a held level is not an edge
    assign exec_rise = exec & ~exec_q & armed;
    assign inst_done = (state == RUN) & ~stall & (p[0] | skip);
    assign leave = halt_req | step | ~go;
    assign busy = state == RUN;
    assign halted = state == HALT;
    always_comb begin
        state_n = state;
        p_n = p;
        if (state == IDLE && (step ? exec_rise : go)) begin
            state_n = RUN;
            p_n = FIRST;
        end else if (state == RUN && !stall) begin
            p_n = !inst_done ? p >> 1 : leave ? '0 : FIRST;
            state_n = !inst_done ? RUN : halt_req ? HALT : leave ? IDLE : RUN;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            p <= '0;
            icount <= '0;
            exec_q <= 1'b0;
            armed <= ~exec;
        end else begin
            state <= state_n;
            p <= p_n;
            icount <= icount + {{(CW-1){1'b0}}, inst_done};
            exec_q <= exec;
            armed <= armed | ~exec;
        end
    end
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed and randomized checks of phase_sequencer against a phase-index reference model.
module tb_phase_sequencer;
    localparam int NPHASE = 5;
    logic clk = 1'b0;
    logic rst, go, step, exec, stall, skip, halt_req;
    logic [NPHASE-1:0] p, p4;
    logic busy, halted, inst_done, busy4, halted4, inst_done4;
    logic [15:0] icount;
    logic [3:0] icount4;
    int passed = 0, total = 0;
    int m_mode, m_ph, m_cnt, c0;
    bit m_prev;

    always #5 clk = ~clk;

    phase_sequencer #(.NPHASE(NPHASE), .CW(16)) dut (
        .clk(clk), .rst(rst), .go(go), .step(step), .exec(exec), .stall(stall), .skip(skip),
        .halt_req(halt_req), .p(p), .busy(busy), .halted(halted), .inst_done(inst_done), .icount(icount));
    phase_sequencer #(.NPHASE(NPHASE), .CW(4)) dut4 (
        .clk(clk), .rst(rst), .go(go), .step(step), .exec(exec), .stall(stall), .skip(skip),
        .halt_req(halt_req), .p(p4), .busy(busy4), .halted(halted4), .inst_done(inst_done4), .icount(icount4));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed = passed + 1;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Model: mode 0 idle / 1 run / 2 halt, m_ph counts phases 1..NPHASE within an instruction.
    task automatic cyc();
        bit done, rise;
        logic [31:0] exp_p;
        #1;
        exp_p = (m_mode == 1) ? 32'(1) << (NPHASE - m_ph) : 32'd0;
        done = (m_mode == 1) && !stall && (m_ph == NPHASE || skip);
        check("p", 32'(p), exp_p);
        check("p4", 32'(p4), exp_p);
        check("busy", 32'(busy), 32'(m_mode == 1));
        check("halted", 32'(halted), 32'(m_mode == 2));
        check("icount", 32'(icount), m_cnt % 65536);
        check("icount4", 32'(icount4), m_cnt % 16);
        if (!rst) check("inst_done", 32'(inst_done), 32'(done));
        rise = exec && !m_prev;
        m_prev = exec;
        if (rst) begin
            m_mode = 0; m_ph = 0; m_cnt = 0;
        end else if (m_mode == 0 && (step ? rise : go)) begin
            m_mode = 1; m_ph = 1;
        end else if (m_mode == 1 && !stall) begin
            if (!done) m_ph++;
            else begin
                m_cnt++;
                m_ph = 1;
                if (halt_req) m_mode = 2;
                else if (step || !go) m_mode = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ph(input int ph);
        for (int n = 0; n < 12 && !(m_mode == 1 && m_ph == ph); n++) cyc();
        #1;
        check("wait_ph", 32'(p), 32'(1) << (NPHASE - ph));
    endtask

    task automatic do_rst();
        rst = 1; cyc(); rst = 0;
    endtask

    initial begin
        {rst, go, step, exec, stall, skip, halt_req} = '0;
        rst = 1;
        @(posedge clk);
        #1;
        m_mode = 0; m_ph = 0; m_cnt = 0; m_prev = exec;
        rst = 0;
        #1;
        check("rst_p", 32'(p), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_icount", 32'(icount), 0);
        go = 1;
        repeat (16) cyc();
        check("run_icount", 32'(icount), 3);
        wait_ph(3);
        stall = 1;
        repeat (3) begin
            #1; check("stall_p", 32'(p), 32'b00100); cyc();
        end
        stall = 0;
        #1; check("stall_end_p", 32'(p), 32'b00100);
        cyc();
        wait_ph(2);
        stall = 1; skip = 1;
        #1; check("skip_stall", 32'(inst_done), 0);
        cyc();
        stall = 0;
        #1; check("skip_done", 32'(inst_done), 1);
        cyc();
        skip = 0;
        check("skip_next_p", 32'(p), 32'b10000);
        go = 0;
        for (int n = 0; n < 10 && m_mode != 0; n++) cyc();
        step = 1; exec = 1; c0 = m_cnt;
        repeat (10) cyc();
        exec = 0;
        repeat (4) cyc();
        check("step_icount", 32'(icount), 32'(c0 + 1));
        check("step_idle_p", 32'(p), 0);
        step = 0; go = 1;
        wait_ph(2);
        halt_req = 1;
        for (int n = 0; n < 10 && m_mode != 2; n++) cyc();
        check("halt_halted", 32'(halted), 1);
        check("halt_p", 32'(p), 0);
        repeat (6) begin
            exec = ~exec; cyc();
        end
        check("halt_stays", 32'(halted), 1);
        halt_req = 0; exec = 0;
        do_rst();
        check("halt_rst_icount", 32'(icount), 0);
        check("halt_rst_halted", 32'(halted), 0);
        skip = 1;
        repeat (17) cyc();
        check("wrap_icount4", 32'(icount4), 0);
        check("wrap_icount", 32'(icount), 16);
        skip = 0;
        wait_ph(4);
        do_rst();
        go = 0;
        #1;
        check("midrst_p", 32'(p), 0);
        check("midrst_icount", 32'(icount), 0);
        check("midrst_done", 32'(inst_done), 0);
        cyc();
        for (int i = 0; i < 1500; i++) begin
            rst = $urandom_range(0, 63) == 0;
            go = $urandom_range(0, 3) != 0;
            step = $urandom_range(0, 3) == 0;
            exec = $urandom_range(0, 2) == 0;
            stall = $urandom_range(0, 3) == 0;
            skip = $urandom_range(0, 5) == 0;
            halt_req = $urandom_range(0, 40) == 0;
            cyc();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
